// File: rtl/bayer_frame_buffer_pkg.sv
// Shared constants and read-FSM encoding for the Bayer ping-pong frame buffer.
package bayer_frame_buffer_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 8;
  localparam int unsigned DEF_ADDRESS    = 14;
  localparam int unsigned DEF_CNT_WIDTH  = 8;
  localparam int unsigned FRAME_PIXELS   = 2 ** DEF_ADDRESS;
  localparam int unsigned IMG_W          = 128;

  typedef enum logic {
    R_IDLE  = 1'b0,
    R_SERVE = 1'b1
  } rd_state_e;

endpackage

// File: rtl/bayer_bank_ram.sv
// Single-clock simple dual-port RAM: one write port, one registered read port.
// The read register holds its value when no read is enabled.
module bayer_bank_ram #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDRESS    = 14
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  we_i,
  input  logic [ADDRESS-1:0]    waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic                  re_i,
  input  logic [ADDRESS-1:0]    raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem [2**ADDRESS];
  logic [DATA_WIDTH-1:0] rdata_q;

  // Write port; contents are never reset.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem[waddr_i] <= wdata_i;
    end
  end

  // Registered read port with synchronous reset of the output register only.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/bayer_frame_buffer.sv
// Ping-pong frame buffer: loads a raster Bayer stream into one bank while the
// other bank is served by random access to the demosaic core.
module bayer_frame_buffer
  import bayer_frame_buffer_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned ADDRESS    = DEF_ADDRESS,
  parameter int unsigned CNT_WIDTH  = DEF_CNT_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pix_valid,
  output logic                  pix_ready,
  input  logic                  pix_sof,
  input  logic [DATA_WIDTH-1:0] pix_data,
  input  logic [ADDRESS-1:0]    bayer_addr,
  input  logic                  bayer_req,
  output logic                  bayer_ready,
  output logic [DATA_WIDTH-1:0] bayer_data,
  input  logic                  finish,
  output logic                  sof_err,
  output logic [CNT_WIDTH-1:0]  frames_done
);

  localparam logic [ADDRESS-1:0] LastAddr = '1;
  localparam logic [ADDRESS-1:0] OneAddr  = ADDRESS'(1);

  // Write side state
  logic [ADDRESS-1:0] wr_ptr_q, wr_ptr_d;
  logic               wr_bank_q, wr_bank_d;
  logic [1:0]         full_q, full_d;
  logic               sof_err_q, sof_err_d;

  // Read side state
  rd_state_e          state_q, state_d;
  logic               rd_bank_q, rd_bank_d;
  logic               ready_q, ready_d;
  logic               rd_sel_q, rd_sel_d;
  logic [CNT_WIDTH-1:0] frames_done_q, frames_done_d;

  // Datapath controls
  logic               accept;
  logic               wr_en;
  logic [ADDRESS-1:0] waddr;
  logic               frame_done;
  logic               release_frame;
  logic               rd_en;
  logic [1:0]         bank_we;
  logic [1:0]         bank_re;
  logic [DATA_WIDTH-1:0] bank_rdata [2];

  assign pix_ready = rst && !full_q[wr_bank_q];

  // Write pointer / bank advance, including resync on an unexpected start-of-frame.
  always_comb begin
    accept     = pix_valid && pix_ready;
    wr_en      = accept;
    waddr      = wr_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    wr_bank_d  = wr_bank_q;
    sof_err_d  = 1'b0;
    frame_done = 1'b0;
    if (accept) begin
      if (pix_sof && (wr_ptr_q != '0)) begin
        // Drop the partial frame and restart this bank at address 0.
        waddr     = '0;
        wr_ptr_d  = OneAddr;
        sof_err_d = 1'b1;
      end else if (wr_ptr_q == LastAddr) begin
        frame_done = 1'b1;
        wr_ptr_d   = '0;
        wr_bank_d  = ~wr_bank_q;
      end else begin
        wr_ptr_d = wr_ptr_q + OneAddr;
      end
    end
  end

  // Read FSM: wait for a full bank, serve it until the core signals finish.
  always_comb begin
    state_d       = state_q;
    ready_d       = ready_q;
    rd_bank_d     = rd_bank_q;
    frames_done_d = frames_done_q;
    release_frame = 1'b0;
    case (state_q)
      R_IDLE: begin
        if (full_q[rd_bank_q]) begin
          state_d = R_SERVE;
          ready_d = 1'b1;
        end
      end
      R_SERVE: begin
        if (finish) begin
          release_frame = 1'b1;
          rd_bank_d     = ~rd_bank_q;
          frames_done_d = frames_done_q + 1'b1;
          ready_d       = 1'b0;
          state_d       = R_IDLE;
        end
      end
      default: begin
        state_d = R_IDLE;
        ready_d = 1'b0;
      end
    endcase
    // Requests in the releasing cycle are dropped.
    rd_en    = bayer_req && ready_q && (state_q == R_SERVE) && !finish;
    rd_sel_d = rd_en ? rd_bank_q : rd_sel_q;
  end

  // Full flags: release and completion target different banks, so both apply.
  always_comb begin
    full_d = full_q;
    if (release_frame) begin
      full_d[rd_bank_q] = 1'b0;
    end
    if (frame_done) begin
      full_d[wr_bank_q] = 1'b1;
    end
  end

  // Per-bank enables
  always_comb begin
    bank_we            = '0;
    bank_re            = '0;
    bank_we[wr_bank_q] = wr_en;
    bank_re[rd_bank_q] = rd_en;
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q      <= '0;
      wr_bank_q     <= 1'b0;
      full_q        <= '0;
      sof_err_q     <= 1'b0;
      state_q       <= R_IDLE;
      rd_bank_q     <= 1'b0;
      ready_q       <= 1'b0;
      rd_sel_q      <= 1'b0;
      frames_done_q <= '0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      wr_bank_q     <= wr_bank_d;
      full_q        <= full_d;
      sof_err_q     <= sof_err_d;
      state_q       <= state_d;
      rd_bank_q     <= rd_bank_d;
      ready_q       <= ready_d;
      rd_sel_q      <= rd_sel_d;
      frames_done_q <= frames_done_d;
    end
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    bayer_bank_ram #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDRESS    (ADDRESS)
    ) u_ram (
      .clk_i   (clk),
      .rst_ni  (rst),
      .we_i    (bank_we[b]),
      .waddr_i (waddr),
      .wdata_i (pix_data),
      .re_i    (bank_re[b]),
      .raddr_i (bayer_addr),
      .rdata_o (bank_rdata[b])
    );
  end

  // Output mux follows the bank most recently read so data holds between requests.
  assign bayer_data  = bank_rdata[rd_sel_q];
  assign bayer_ready = ready_q;
  assign sof_err     = sof_err_q;
  assign frames_done = frames_done_q;

endmodule

// File: tb/tb_bayer_frame_buffer.sv
`timescale 1ns/1ps
module tb_bayer_frame_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic        pix_valid;
  logic        pix_ready;
  logic        pix_sof;
  logic [7:0]  pix_data;
  logic [13:0] bayer_addr;
  logic        bayer_req;
  logic        bayer_ready;
  logic [7:0]  bayer_data;
  logic        finish;
  logic        sof_err;
  logic [7:0]  frames_done;

  int n_tests = 0;
  int n_fail  = 0;

  // Read-data scoreboard
  string      nm_q[$];
  logic [7:0] d_q[$];

  always #5 clk = ~clk;

  bayer_frame_buffer dut (
    .clk         (clk),
    .rst         (rst),
    .pix_valid   (pix_valid),
    .pix_ready   (pix_ready),
    .pix_sof     (pix_sof),
    .pix_data    (pix_data),
    .bayer_addr  (bayer_addr),
    .bayer_req   (bayer_req),
    .bayer_ready (bayer_ready),
    .bayer_data  (bayer_data),
    .finish      (finish),
    .sof_err     (sof_err),
    .frames_done (frames_done)
  );

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
    end
  endtask

  function automatic logic [7:0] pat(input int mode, input int a);
    logic [13:0] ad;
    ad = a[13:0];
    case (mode)
      0:       return ad[7:0];
      1:       return ~ad[7:0];
      2:       return 8'h33;
      default: return ad[7:0] ^ 8'h55;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One read cycle; expected data is pushed for the monitor.
  task automatic rd(input string nm, input int addr, input bit req, input logic [7:0] e);
    bayer_addr = addr[13:0];
    bayer_req  = req;
    tick();
    bayer_req  = 1'b0;
    nm_q.push_back(nm);
    d_q.push_back(e);
  endtask

  // Stream pixels first..first+n-1; optionally raise finish with the last one.
  task automatic stream(input int first, input int n, input int mode, input bit fin_last);
    int a;
    int w;
    for (int i = 0; i < n; i++) begin
      a         = first + i;
      pix_valid = 1'b1;
      pix_data  = pat(mode, a);
      pix_sof   = (a == 0);
      if (fin_last && (i == n - 1)) finish = 1'b1;
      w = 0;
      while (!pix_ready && w < 16) begin
        tick();
        w++;
      end
      if (!pix_ready) begin
        chk("stream_stall", {31'b0, pix_ready}, 32'd1);
        pix_valid = 1'b0;
        pix_sof   = 1'b0;
        finish    = 1'b0;
        return;
      end
      tick();
      finish = 1'b0;
    end
    pix_valid = 1'b0;
    pix_sof   = 1'b0;
  endtask

  // Monitor: compare read data one cycle after each recorded request.
  initial begin
    string      nm;
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (d_q.size() > 0) begin
        nm = nm_q.pop_front();
        e  = d_q.pop_front();
        chk(nm, {24'b0, bayer_data}, {24'b0, e});
      end
    end
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; pix_valid = 1'b0; pix_sof = 1'b0; pix_data = '0;
    bayer_addr = '0; bayer_req = 1'b0; finish = 1'b0;
    tick(); tick();
    chk("rst_pix_ready",   {31'b0, pix_ready},   32'd0);
    chk("rst_bayer_ready", {31'b0, bayer_ready}, 32'd0);
    chk("rst_bayer_data",  {24'b0, bayer_data},  32'd0);
    chk("rst_sof_err",     {31'b0, sof_err},     32'd0);
    chk("rst_frames_done", {24'b0, frames_done}, 32'd0);
    rst = 1'b1;
    #1;
    chk("pix_ready_after_rst", {31'b0, pix_ready}, 32'd1);

    // Request before any frame is complete is ignored.
    rd("req_not_ready_a", 5, 1'b1, 8'h00);

    // Partial frame, then reset mid-load.
    stream(0, 8000, 2, 1'b0);
    chk("partial_not_ready", {31'b0, bayer_ready}, 32'd0);
    rd("req_not_ready_b", 5, 1'b1, 8'h00);
    rst = 1'b0;
    tick();
    chk("midrst_pix_ready",   {31'b0, pix_ready},   32'd0);
    chk("midrst_bayer_ready", {31'b0, bayer_ready}, 32'd0);
    chk("midrst_bayer_data",  {24'b0, bayer_data},  32'd0);
    chk("midrst_frames_done", {24'b0, frames_done}, 32'd0);
    rst = 1'b1;

    // Frame 0: data = addr[7:0].
    stream(0, 16384, 0, 1'b0);
    chk("f0_ready_early", {31'b0, bayer_ready}, 32'd0);
    tick();
    chk("f0_ready",       {31'b0, bayer_ready}, 32'd1);
    chk("f0_pix_ready",   {31'b0, pix_ready},   32'd1);
    rd("f0_rd129",   129,   1'b1, 8'h81);
    rd("f0_rd16383", 16383, 1'b1, 8'hFF);
    rd("f0_hold",    3,     1'b0, 8'hFF);
    rd("f0_rd8000",  8000,  1'b1, 8'h40);
    rd("f0_rd0",     0,     1'b1, 8'h00);

    // Frame 1 (data = ~addr) with a stray start-of-frame at wr_ptr 500.
    stream(0, 500, 1, 1'b0);
    pix_valid = 1'b1; pix_sof = 1'b1; pix_data = 8'hAA;
    tick();
    pix_valid = 1'b0; pix_sof = 1'b0;
    chk("sof_err_pulse", {31'b0, sof_err}, 32'd1);
    tick();
    chk("sof_err_clear", {31'b0, sof_err}, 32'd0);
    stream(1, 16382, 1, 1'b0);
    chk("f1_not_full", {31'b0, pix_ready}, 32'd1);
    stream(16383, 1, 1, 1'b0);
    chk("f1_full_stall", {31'b0, pix_ready}, 32'd0);
    chk("f0_still_served", {31'b0, bayer_ready}, 32'd1);
    rd("f0_rd200", 200, 1'b1, 8'hC8);

    // Frame 2's first pixel stalls until the release.
    pix_valid = 1'b1; pix_sof = 1'b1; pix_data = 8'h01;
    for (int i = 0; i < 3; i++) begin
      chk("stall_pix_ready", {31'b0, pix_ready}, 32'd0);
      tick();
    end
    finish = 1'b1;
    tick();
    finish = 1'b0;
    chk("fin0_ready_low",   {31'b0, bayer_ready}, 32'd0);
    chk("fin0_pix_ready",   {31'b0, pix_ready},   32'd1);
    chk("fin0_frames_done", {24'b0, frames_done}, 32'd1);
    pix_valid = 1'b0; pix_sof = 1'b0;
    tick();
    chk("f1_ready", {31'b0, bayer_ready}, 32'd1);
    rd("f1_rd0",     0,     1'b1, 8'hAA);
    rd("f1_rd16383", 16383, 1'b1, 8'h00);
    rd("f1_rd129",   129,   1'b1, 8'h7E);

    // Frame 2 completes in the same cycle frame 1 is released.
    stream(0, 16383, 3, 1'b0);
    bayer_req = 1'b1; bayer_addr = 14'd5;
    stream(16383, 1, 3, 1'b1);
    bayer_req = 1'b0;
    nm_q.push_back("fin_req_ignored");
    d_q.push_back(8'h7E);
    chk("sim_ready_low",   {31'b0, bayer_ready}, 32'd0);
    chk("sim_pix_ready",   {31'b0, pix_ready},   32'd1);
    chk("sim_frames_done", {24'b0, frames_done}, 32'd2);
    tick();
    chk("f2_ready",     {31'b0, bayer_ready}, 32'd1);
    chk("f2_pix_ready", {31'b0, pix_ready},   32'd1);
    rd("f2_rd10",    10,    1'b1, 8'h5F);
    rd("f2_rd16383", 16383, 1'b1, 8'hAA);

    tick(); tick(); tick();
    chk("sb_drain", d_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
